sr_cmd_conditioner: RTL and testbench
=====================================

// Module: sr_cmd_conditioner
// PURPOSE
//  Upstream stage of the SR latch: turns two raw, asynchronous, bouncy request lines (set/clear)
//  into clean single-purpose S/R pulses. Synchronises and debounces each input, detects rising
//  edges and arbitrates conflicts. Guarantees the latch never sees S=R=1 (its forbidden state).
//  Tracks the expected latch state so redundant requests are dropped.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable synced cycles required to accept a new level (>=1)
//  PULSE_W          2  cycles S or R is held high per command (>=1)
//  HOLDOFF          1  idle cycles forced after each pulse before the next command (>=0)
//  RESET_WINS       1  1: clear beats set on simultaneous requests; 0: set beats clear
// PORTS
//  clk          in   1  single clock; all logic on rising edge
//  rst          in   1  synchronous, active-high reset
//  set_raw      in   1  raw set request (async, may bounce)
//  clr_raw      in   1  raw clear request (async, may bounce)
//  S            out  1  set pulse to latch; registered
//  R            out  1  reset pulse to latch; registered
//  q_track      out  1  expected latch Q; updates on the cycle after a pulse's last cycle
//  busy         out  1  high in PULSE_S/PULSE_R/HOLDOFF
//  conflict     out  1  one-cycle flag: both requests seen in the same cycle
// BEHAVIOUR
//  Reset: S=0, R=0, q_track=0, busy=0, conflict=0; sync flops, debounced levels, counters and
//   pending bits cleared; FSM->IDLE. A reset mid-pulse drops S/R on the next edge; pending lost.
//  Per input: 2-flop synchroniser; counter increments while synced != debounced, clears when
//   equal; when it would reach DEBOUNCE_CYCLES the debounced level toggles and counter clears.
//   Request = debounced rising edge (1 cycle). Falling edges generate nothing.
//  Latency: raw stable high sampled first at edge k -> S/R high from edge k+2+DEBOUNCE_CYCLES
//   (2 sync + debounce + 1 registered output), provided the FSM is IDLE.
//  Inputs held high through reset debounce to 1 after rst falls and DO issue a request.
//  FSM states: IDLE, PULSE_S, PULSE_R, HOLDOFF.
//   IDLE: pick request from {new requests | pending}; both present -> RESET_WINS selects,
//    loser discarded, conflict=1 for that cycle (also when both come from pending).
//    set chosen & q_track=0 -> PULSE_S; clear chosen & q_track=1 -> PULSE_R;
//    redundant (set with q_track=1 / clear with q_track=0) -> dropped, stay IDLE.
//   PULSE_S/PULSE_R: S (resp. R) high exactly PULSE_W cycles; pulse-width counter
//    width $clog2(PULSE_W+1). On exit q_track set to 1 (resp. 0); -> HOLDOFF, or IDLE if HOLDOFF=0.
//   HOLDOFF: S=R=0 for HOLDOFF cycles -> IDLE.
//  While busy: new requests set a 1-deep pending bit per input (repeats coalesce); serviced
//   on the first IDLE cycle with the arbitration rules above.
//  Invariant: S & R never both 1; S/R only change on clk edge; no glitch on outputs.
//  Counter widths: $clog2(DEBOUNCE_CYCLES+1), $clog2(HOLDOFF+1) (min 1 bit); no wrap possible.
// STRUCTURE
//  Package sr_cond_pkg: FSM state enum (IDLE/PULSE_S/PULSE_R/HOLDOFF), request-select typedef,
//   helper function for minimum-1-bit clog2 widths.
//  Sub-module sr_debounce (synchroniser + debounce counter + rising-edge detect), instantiated
//   once for set_raw and once for clr_raw; top holds arbitration, pending bits, FSM, q_track.
// TESTING (defaults unless noted)
//  1 set_raw 0->1 held 20 cycles -> S high for exactly 2 cycles starting 6 edges after first
//    sample; q_track=1 the cycle after; R stays 0.
//  2 set_raw bounces 1,0,1,0 (1-cycle glitches) then stable 1 -> no S during bounce; one S pulse
//    only after 4 stable synced cycles.
//  3 set_raw and clr_raw rise same cycle, q_track=0, RESET_WINS=1 -> conflict=1 one cycle,
//    clear redundant -> no pulse; repeat with RESET_WINS=0 -> S pulse, q_track=1.
//  4 clr request arrives during PULSE_S -> pending; after HOLDOFF, R pulses 2 cycles, q_track=0;
//    S and R never overlap (assertion over whole run).
//  5 set request with q_track=1 -> no S, busy stays 0.
//  6 rst asserted on 1st cycle of PULSE_S -> next edge S=0, q_track=0, busy=0; set_raw held
//    high -> after rst falls a fresh S pulse at the normal latency.

Source files
------------

// File: rtl/sr_cond_pkg.sv
// Shared types and width helper for the SR latch command conditioner.
package sr_cond_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPulseS,
    StPulseR,
    StHoldoff
  } cond_state_e;

  typedef enum logic [1:0] {
    ReqNone,
    ReqSet,
    ReqClr
  } req_sel_e;

  // Counter width able to hold val-1, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned val);
    return (val <= 1) ? 1 : $clog2(val);
  endfunction

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchroniser, stability counter and registered rising-edge detect for one raw line.
module sr_debounce
  import sr_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic rise_o
);

  localparam int unsigned CntW = clog2_min1(DEBOUNCE_CYCLES + 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      // Flip the accepted level on the cycle the count would reach DEBOUNCE_CYCLES.
      if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    rise_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns bouncy set/clear request lines into clean, arbitrated, non-overlapping S/R pulses
// and tracks the latch state so redundant requests never reach it.
module sr_cmd_conditioner
  import sr_cond_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_W         = 2,
  parameter int unsigned HOLDOFF         = 1,
  parameter bit          RESET_WINS      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic set_raw,
  input  logic clr_raw,
  output logic S,
  output logic R,
  output logic q_track,
  output logic busy,
  output logic conflict
);

  localparam int unsigned PwW = clog2_min1(PULSE_W + 1);
  localparam int unsigned HoW = clog2_min1(HOLDOFF + 1);

  logic set_rise, clr_rise;

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_set (
    .clk_i (clk),
    .rst_i (rst),
    .raw_i (set_raw),
    .rise_o(set_rise)
  );

  sr_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clr (
    .clk_i (clk),
    .rst_i (rst),
    .raw_i (clr_raw),
    .rise_o(clr_rise)
  );

  cond_state_e    state_q, state_d;
  req_sel_e       sel;
  logic [PwW-1:0] pw_cnt_q, pw_cnt_d;
  logic [HoW-1:0] ho_cnt_q, ho_cnt_d;
  logic           q_track_q, q_track_d;
  logic           pend_set_q, pend_set_d, pend_clr_q, pend_clr_d;
  logic           want_set, want_clr;
  logic           s_q, s_d, r_q, r_d, busy_q, busy_d, conflict_q, conflict_d;

  always_comb begin
    state_d    = state_q;
    pw_cnt_d   = pw_cnt_q;
    ho_cnt_d   = ho_cnt_q;
    q_track_d  = q_track_q;
    pend_set_d = pend_set_q;
    pend_clr_d = pend_clr_q;
    conflict_d = 1'b0;
    sel        = ReqNone;
    want_set   = set_rise | pend_set_q;
    want_clr   = clr_rise | pend_clr_q;

    if (state_q != StIdle) begin
      pend_set_d = pend_set_q | set_rise;
      pend_clr_d = pend_clr_q | clr_rise;
    end

    unique case (state_q)
      StIdle: begin
        pend_set_d = 1'b0;
        pend_clr_d = 1'b0;
        if (want_set && want_clr) begin
          conflict_d = 1'b1;
          sel        = RESET_WINS ? ReqClr : ReqSet;
        end else if (want_set) begin
          sel = ReqSet;
        end else if (want_clr) begin
          sel = ReqClr;
        end
        // Requests that would not change the latch are dropped here.
        if (sel == ReqSet && !q_track_q) begin
          state_d  = StPulseS;
          pw_cnt_d = PwW'(1);
        end else if (sel == ReqClr && q_track_q) begin
          state_d  = StPulseR;
          pw_cnt_d = PwW'(1);
        end
      end
      StPulseS, StPulseR: begin
        if (pw_cnt_q == PwW'(PULSE_W)) begin
          q_track_d = (state_q == StPulseS);
          ho_cnt_d  = HoW'(1);
          state_d   = (HOLDOFF == 0) ? StIdle : StHoldoff;
        end else begin
          pw_cnt_d = pw_cnt_q + 1'b1;
        end
      end
      StHoldoff: begin
        if (ho_cnt_q == HoW'(HOLDOFF)) begin
          state_d = StIdle;
        end else begin
          ho_cnt_d = ho_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    s_d    = (state_d == StPulseS);
    r_d    = (state_d == StPulseR);
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      pw_cnt_q   <= '0;
      ho_cnt_q   <= '0;
      q_track_q  <= 1'b0;
      pend_set_q <= 1'b0;
      pend_clr_q <= 1'b0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      busy_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pw_cnt_q   <= pw_cnt_d;
      ho_cnt_q   <= ho_cnt_d;
      q_track_q  <= q_track_d;
      pend_set_q <= pend_set_d;
      pend_clr_q <= pend_clr_d;
      s_q        <= s_d;
      r_q        <= r_d;
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

  assign S        = s_q;
  assign R        = r_q;
  assign q_track  = q_track_q;
  assign busy     = busy_q;
  assign conflict = conflict_q;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Bench for sr_cmd_conditioner: two instances (clear-wins and set-wins) share stimulus and are
// compared every cycle against a timestamp-based reference model.
module tb_sr_cmd_conditioner;

  localparam int DEB  = 4;
  localparam int PW   = 2;
  localparam int HO   = 1;
  localparam int MAXC = 8192;

  logic       clk, rst, set_raw, clr_raw;
  logic [1:0] s_o, r_o, q_o, busy_o, conf_o;

  sr_cmd_conditioner u_dut_cw (
    .clk     (clk),
    .rst     (rst),
    .set_raw (set_raw),
    .clr_raw (clr_raw),
    .S       (s_o[0]),
    .R       (r_o[0]),
    .q_track (q_o[0]),
    .busy    (busy_o[0]),
    .conflict(conf_o[0])
  );

  sr_cmd_conditioner #(.RESET_WINS(1'b0)) u_dut_sw (
    .clk     (clk),
    .rst     (rst),
    .set_raw (set_raw),
    .clr_raw (clr_raw),
    .S       (s_o[1]),
    .R       (r_o[1]),
    .q_track (q_o[1]),
    .busy    (busy_o[1]),
    .conflict(conf_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Input history per line (0 = set, 1 = clr), indexed by edge number.
  bit samp [2][MAXC];
  bit syn  [2][MAXC];
  bit rise [2][MAXC];
  bit deb  [2];
  int last_tog [2];

  // Per-instance command schedule, as edge numbers.
  int idle_from [2];
  int s_from [2], s_to [2], r_from [2], r_to [2];
  int qt_edge [2], conf_edge [2];
  bit qt_val [2], qtrack [2], pend_s [2], pend_c [2];

  task automatic model_edge(input int n);
    bit raw, stable, ns, nc, ws, wc;
    for (int k = 0; k < 2; k++) begin
      raw = (k == 0) ? set_raw : clr_raw;
      if (rst) begin
        samp[k][n] = 1'b0;
        syn[k][n]  = 1'b0;
        rise[k][n] = 1'b0;
        deb[k]     = 1'b0;
        last_tog[k] = n;
      end else begin
        syn[k][n]  = samp[k][n-1];
        samp[k][n] = raw;
        // Level flips once the synced line has disagreed for DEB straight cycles since last flip.
        stable = (n - DEB >= last_tog[k]);
        if (stable) begin
          for (int j = n - DEB; j < n; j++) begin
            if (syn[k][j] == deb[k]) stable = 1'b0;
          end
        end
        rise[k][n] = stable && !deb[k];
        if (stable) begin
          deb[k]      = !deb[k];
          last_tog[k] = n;
        end
      end
    end
    for (int f = 0; f < 2; f++) begin
      if (rst) begin
        idle_from[f] = n;
        s_from[f] = -1; s_to[f] = -2; r_from[f] = -1; r_to[f] = -2;
        qt_edge[f] = -1; conf_edge[f] = -1;
        qtrack[f] = 1'b0; pend_s[f] = 1'b0; pend_c[f] = 1'b0;
      end else begin
        ns = rise[0][n-1];
        nc = rise[1][n-1];
        if (n - 1 >= idle_from[f]) begin
          ws = ns | pend_s[f];
          wc = nc | pend_c[f];
          pend_s[f] = 1'b0;
          pend_c[f] = 1'b0;
          if (ws && wc) begin
            conf_edge[f] = n;
            if (f == 0) ws = 1'b0;
            else wc = 1'b0;
          end
          if (ws && !qtrack[f]) begin
            s_from[f] = n; s_to[f] = n + PW - 1;
            qt_edge[f] = n + PW; qt_val[f] = 1'b1;
            idle_from[f] = n + PW + HO;
          end else if (wc && qtrack[f]) begin
            r_from[f] = n; r_to[f] = n + PW - 1;
            qt_edge[f] = n + PW; qt_val[f] = 1'b0;
            idle_from[f] = n + PW + HO;
          end
        end else begin
          pend_s[f] = pend_s[f] | ns;
          pend_c[f] = pend_c[f] | nc;
        end
        if (n == qt_edge[f]) qtrack[f] = qt_val[f];
      end
    end
  endtask

  task automatic compare_outputs();
    for (int f = 0; f < 2; f++) begin
      check_eq($sformatf("S[%0d]", f), s_o[f], (cyc >= s_from[f] && cyc <= s_to[f]));
      check_eq($sformatf("R[%0d]", f), r_o[f], (cyc >= r_from[f] && cyc <= r_to[f]));
      check_eq($sformatf("q_track[%0d]", f), q_o[f], qtrack[f]);
      check_eq($sformatf("busy[%0d]", f), busy_o[f], (cyc < idle_from[f]));
      check_eq($sformatf("conflict[%0d]", f), conf_o[f], (cyc == conf_edge[f]));
      check_eq($sformatf("no_overlap[%0d]", f), s_o[f] & r_o[f], 1'b0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    if (cyc >= MAXC) begin
      $display("FAIL cycle_budget: got %0d, expected below %0d", cyc, MAXC);
      $fatal(1, "cycle budget exhausted");
    end
    model_edge(cyc);
    #1;
    compare_outputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  int k0, first_s, first_r, s_cnt, r_cnt, c_cnt0, c_cnt1, s_cnt1, b_cnt, rises;
  bit prev_s;

  initial begin
    rst = 1'b1; set_raw = 1'b0; clr_raw = 1'b0;
    ticks(3);
    check_eq("reset_S", s_o[0], 1'b0);
    check_eq("reset_q_track", q_o[0], 1'b0);
    check_eq("reset_busy", busy_o[0], 1'b0);
    rst = 1'b0;
    ticks(5);

    // Clean set: S exactly PW cycles at fixed latency, then q_track high.
    set_raw = 1'b1; k0 = cyc + 1; first_s = -1; s_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_o[0]) begin
        if (first_s < 0) first_s = cyc;
        s_cnt++;
      end
    end
    check_eq("set_latency", first_s - k0, 6);
    check_eq("set_width", s_cnt, PW);
    check_eq("set_q_track", q_o[0], 1'b1);
    set_raw = 1'b0; ticks(10);
    clr_raw = 1'b1; ticks(15); clr_raw = 1'b0; ticks(10);
    check_eq("clr_q_track", q_o[0], 1'b0);

    // Bounce before a stable high: exactly one S pulse.
    rises = 0; prev_s = 1'b0;
    set_raw = 1'b1; tick(); set_raw = 1'b0; tick();
    set_raw = 1'b1; tick(); set_raw = 1'b0; tick();
    set_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_o[0] && !prev_s) rises++;
      prev_s = s_o[0];
    end
    check_eq("bounce_one_pulse", rises, 1);
    set_raw = 1'b0; ticks(10);
    clr_raw = 1'b1; ticks(15); clr_raw = 1'b0; ticks(10);

    // Simultaneous requests with q_track=0: clear-wins drops, set-wins pulses S.
    c_cnt0 = 0; c_cnt1 = 0; s_cnt = 0; s_cnt1 = 0;
    set_raw = 1'b1; clr_raw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      c_cnt0 += int'(conf_o[0]); c_cnt1 += int'(conf_o[1]);
      s_cnt  += int'(s_o[0]);    s_cnt1 += int'(s_o[1]);
    end
    check_eq("conflict_cw", c_cnt0, 1);
    check_eq("conflict_sw", c_cnt1, 1);
    check_eq("conflict_cw_no_S", s_cnt, 0);
    check_eq("conflict_sw_S", s_cnt1, PW);
    check_eq("conflict_sw_q", q_o[1], 1'b1);
    set_raw = 1'b0; clr_raw = 1'b0; ticks(10);

    // Clear arriving during PULSE_S is held pending and serviced after holdoff.
    set_raw = 1'b1; k0 = cyc + 1;
    ticks(2);
    clr_raw = 1'b1; first_r = -1; r_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (r_o[0]) begin
        if (first_r < 0) first_r = cyc;
        r_cnt++;
      end
    end
    check_eq("pending_R_start", first_r - k0, 6 + PW + HO + 1);
    check_eq("pending_R_width", r_cnt, PW);
    check_eq("pending_q_track", q_o[0], 1'b0);
    set_raw = 1'b0; clr_raw = 1'b0; ticks(10);

    // Redundant set with q_track=1 leaves busy low.
    set_raw = 1'b1; ticks(15); set_raw = 1'b0; ticks(10);
    b_cnt = 0;
    set_raw = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      b_cnt += int'(busy_o[0]);
    end
    check_eq("redundant_busy", b_cnt, 0);
    set_raw = 1'b0; ticks(10);

    // Reset on the first S cycle, then set held high reissues S at normal latency.
    rst = 1'b1; ticks(2); rst = 1'b0; ticks(3);
    set_raw = 1'b1;
    for (int i = 0; i < 30 && !s_o[0]; i++) tick();
    check_eq("pre_reset_S_seen", s_o[0], 1'b1);
    rst = 1'b1; tick();
    check_eq("mid_reset_S", s_o[0], 1'b0);
    check_eq("mid_reset_busy", busy_o[0], 1'b0);
    check_eq("mid_reset_q", q_o[0], 1'b0);
    rst = 1'b0; k0 = cyc + 1;
    for (int i = 0; i < 30 && !s_o[0]; i++) tick();
    check_eq("post_reset_latency", cyc - k0, 6);
    set_raw = 1'b0; ticks(10);

    // Random soak with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(5) == 0) set_raw = ~set_raw;
      if ($urandom_range(5) == 0) clr_raw = ~clr_raw;
      rst = ($urandom_range(299) == 0);
      tick();
    end
    rst = 1'b0; set_raw = 1'b0; clr_raw = 1'b0;
    ticks(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
